// File: rtl/bot_io_pkg.sv
// Shared constants for the PicoBlaze bot I/O bridge: port addresses,
// blank digit code and the interrupt controller state encoding.
package bot_io_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DIGIT_W = 5;

  localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 5'h1F;

  // Read-side addresses
  localparam logic [DATA_W-1:0] ADDR_BTNS     = 8'h00;
  localparam logic [DATA_W-1:0] ADDR_SW_LO    = 8'h01;
  localparam logic [DATA_W-1:0] ADDR_SW_HI    = 8'h02;
  localparam logic [DATA_W-1:0] ADDR_LOC_X    = 8'h0A;
  localparam logic [DATA_W-1:0] ADDR_LOC_Y    = 8'h0B;
  localparam logic [DATA_W-1:0] ADDR_BOT_INFO = 8'h0C;
  localparam logic [DATA_W-1:0] ADDR_SENSORS  = 8'h0D;
  localparam logic [DATA_W-1:0] ADDR_STATUS   = 8'h0E;

  // Write-side addresses
  localparam logic [DATA_W-1:0] ADDR_LED_LO     = 8'h01;
  localparam logic [DATA_W-1:0] ADDR_LED_HI     = 8'h02;
  localparam logic [DATA_W-1:0] ADDR_MOT_CTL    = 8'h09;
  localparam logic [DATA_W-1:0] ADDR_INT_CLR    = 8'h0F;
  localparam logic [DATA_W-1:0] ADDR_DIGIT_BASE = 8'h10;
  localparam logic [DATA_W-1:0] ADDR_DP_LO      = 8'h20;
  localparam logic [DATA_W-1:0] ADDR_DP_HI      = 8'h21;

  typedef enum logic {
    INT_IDLE    = 1'b0,
    INT_PENDING = 1'b1
  } int_state_e;

endpackage

// File: rtl/bot_io_intc.sv
// Interrupt controller: detects upd_sysregs rising edges, tracks the
// pending/overrun flags and drives the interrupt line (level or pulse).
// Ports:
//   clk, reset        clock, async active-low reset
//   upd_sysregs       simulator update flag
//   interrupt_ack     PicoBlaze acknowledge
//   clr_overrun       clear request for the sticky overrun flag
//   capture_c         combinational rising-edge strobe (shadow load)
//   pending, overrun  status flags
//   interrupt         interrupt request
module bot_io_intc
  import bot_io_pkg::*;
#(
  parameter int unsigned INT_MODE = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic upd_sysregs,
  input  logic interrupt_ack,
  input  logic clr_overrun,
  output logic capture_c,
  output logic pending,
  output logic overrun,
  output logic interrupt
);

  int_state_e state_q, state_d;
  logic       upd_q;
  logic       overrun_q, overrun_d;
  logic       interrupt_q, interrupt_d;

  assign capture_c = upd_sysregs & ~upd_q;
  assign pending   = (state_q == INT_PENDING);
  assign overrun   = overrun_q;
  assign interrupt = interrupt_q;

  // State and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= INT_IDLE;
      upd_q       <= 1'b0;
      overrun_q   <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      upd_q       <= upd_sysregs;
      overrun_q   <= overrun_d;
      interrupt_q <= interrupt_d;
    end
  end

  // Next state; a new edge beats a coincident ack and is not an overrun
  always_comb begin
    state_d     = state_q;
    overrun_d   = overrun_q;
    interrupt_d = 1'b0;

    if (clr_overrun) overrun_d = 1'b0;

    case (state_q)
      INT_IDLE: begin
        if (capture_c) state_d = INT_PENDING;
      end
      INT_PENDING: begin
        if (capture_c) begin
          state_d = INT_PENDING;
          if (!interrupt_ack) overrun_d = 1'b1;
        end else if (interrupt_ack) begin
          state_d = INT_IDLE;
        end
      end
      default: state_d = INT_IDLE;
    endcase

    if (INT_MODE == 0) interrupt_d = (state_d == INT_PENDING);
    else               interrupt_d = (state_q == INT_IDLE) && (state_d == INT_PENDING);
  end

endmodule

// File: rtl/bot_io_bridge.sv
// PicoBlaze I/O bridge for the bot simulator: write registers (LEDs, motor,
// seven-segment digits, decimal points), registered read mux, shadowed
// simulator registers and interrupt controller.
// Ports:
//   clk, reset                     clock, async active-low reset
//   port_id, out_port, in_port     PicoBlaze address / write data / read data
//   write_strobe, read_strobe      PicoBlaze strobes
//   interrupt, interrupt_ack       interrupt request / acknowledge
//   db_btns, db_sw                 debounced buttons and switches
//   loc_x, loc_y, bot_info, sensors, upd_sysregs  simulator registers + update flag
//   mot_ctl, led, digits, dp       motor control, LEDs, digit codes, decimal points
module bot_io_bridge
  import bot_io_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned LED_WIDTH  = 16,
  parameter int unsigned SW_WIDTH   = 16,
  parameter int unsigned BTN_WIDTH  = 4,
  parameter int unsigned INT_MODE   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                port_id,
  input  logic [7:0]                out_port,
  output logic [7:0]                in_port,
  input  logic                      write_strobe,
  input  logic                      read_strobe,
  input  logic                      interrupt_ack,
  output logic                      interrupt,
  input  logic [BTN_WIDTH-1:0]      db_btns,
  input  logic [SW_WIDTH-1:0]       db_sw,
  input  logic [7:0]                loc_x,
  input  logic [7:0]                loc_y,
  input  logic [7:0]                bot_info,
  input  logic [7:0]                sensors,
  input  logic                      upd_sysregs,
  output logic [7:0]                mot_ctl,
  output logic [LED_WIDTH-1:0]      led,
  output logic [NUM_DIGITS*5-1:0]   digits,
  output logic [NUM_DIGITS-1:0]     dp
);

  localparam int unsigned DIGITS_W = NUM_DIGITS * DIGIT_W;

  logic [DATA_W-1:0]     mot_q, in_q, rd_c;
  logic [DATA_W-1:0]     loc_x_q, loc_y_q, bot_info_q, sensors_q;
  logic [LED_WIDTH-1:0]  led_q;
  logic [DIGITS_W-1:0]   digits_q;
  logic [NUM_DIGITS-1:0] dp_q;
  logic [15:0]           sw_c;
  logic                  capture_c, pending, overrun, clr_overrun_c;
  logic                  unused_c;

  // Reads have no side effects, so the read strobe is not needed
  assign unused_c = ^{1'b0, read_strobe};

  assign sw_c          = 16'(db_sw);
  assign clr_overrun_c = write_strobe && (port_id == ADDR_INT_CLR) && out_port[0];

  assign mot_ctl = mot_q;
  assign led     = led_q;
  assign digits  = digits_q;
  assign dp      = dp_q;
  assign in_port = in_q;

  bot_io_intc #(
    .INT_MODE (INT_MODE)
  ) u_intc (
    .clk           (clk),
    .reset         (reset),
    .upd_sysregs   (upd_sysregs),
    .interrupt_ack (interrupt_ack),
    .clr_overrun   (clr_overrun_c),
    .capture_c     (capture_c),
    .pending       (pending),
    .overrun       (overrun),
    .interrupt     (interrupt)
  );

  // Read mux; unmapped addresses return zero
  always_comb begin
    rd_c = '0;
    case (port_id)
      ADDR_BTNS:     rd_c = 8'(db_btns);
      ADDR_SW_LO:    rd_c = sw_c[7:0];
      ADDR_SW_HI:    rd_c = sw_c[15:8];
      ADDR_LOC_X:    rd_c = loc_x_q;
      ADDR_LOC_Y:    rd_c = loc_y_q;
      ADDR_BOT_INFO: rd_c = bot_info_q;
      ADDR_SENSORS:  rd_c = sensors_q;
      ADDR_STATUS:   rd_c = {6'b0, overrun, pending};
      default:       rd_c = '0;
    endcase
  end

  // Register file, shadow capture and registered read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mot_q      <= '0;
      led_q      <= '0;
      digits_q   <= {NUM_DIGITS{DIGIT_BLANK}};
      dp_q       <= '0;
      in_q       <= '0;
      loc_x_q    <= '0;
      loc_y_q    <= '0;
      bot_info_q <= '0;
      sensors_q  <= '0;
    end else begin
      in_q <= rd_c;

      if (capture_c) begin
        loc_x_q    <= loc_x;
        loc_y_q    <= loc_y;
        bot_info_q <= bot_info;
        sensors_q  <= sensors;
      end

      if (write_strobe) begin
        if (port_id == ADDR_MOT_CTL) mot_q <= out_port;

        // Bits past the configured widths have no register and are dropped
        for (int i = 0; i < LED_WIDTH; i++) begin
          if (i < 8 && port_id == ADDR_LED_LO)  led_q[i] <= out_port[3'(i)];
          if (i >= 8 && port_id == ADDR_LED_HI) led_q[i] <= out_port[3'(i - 8)];
        end

        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (port_id == 8'(ADDR_DIGIT_BASE + i)) digits_q[5*i +: 5] <= out_port[4:0];
          if (i < 8 && port_id == ADDR_DP_LO)  dp_q[i] <= out_port[3'(i)];
          if (i >= 8 && port_id == ADDR_DP_HI) dp_q[i] <= out_port[3'(i - 8)];
        end
      end
    end
  end

endmodule
